// File: rtl/div_unit_pkg.sv
// Shared core definitions for the divide unit: operand width, op encodings,
// FSM states and small op-decode helpers.
package div_unit_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } div_state_e;

  localparam logic [5:0] LAST_STEP = 6'd31;

  function automatic logic op_is_signed(logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU) with a registered
// register-file writeback port; 32 shift-subtract steps plus a sign fix-up.
module div_unit #(
  parameter int unsigned XLEN = div_unit_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            reg_wr_en_o,
  output logic [4:0]      reg_dr_o,
  output logic [XLEN-1:0] reg_data_o
);
  import div_unit_pkg::*;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            is_rem_q, is_rem_d;
  logic [4:0]      rd_q, rd_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      dr_q, dr_d;
  logic [XLEN-1:0] data_q, data_d;

  logic            busy;
  logic            signed_op, rem_op, a_neg, b_neg;
  logic            div_zero, overflow;
  logic [XLEN-1:0] a_mag, b_mag, special_res, fix_res;
  logic [XLEN:0]   rem_shift;
  logic            step_ge;
  logic [XLEN-1:0] rem_step;

  always_comb begin
    busy      = (state_q == ST_CALC) || (state_q == ST_FIX);
    signed_op = op_is_signed(op_i);
    rem_op    = op_is_rem(op_i);
    a_neg     = signed_op & rs1_data_i[XLEN-1];
    b_neg     = signed_op & rs2_data_i[XLEN-1];
    a_mag     = a_neg ? (~rs1_data_i + 1'b1) : rs1_data_i;
    b_mag     = b_neg ? (~rs2_data_i + 1'b1) : rs2_data_i;
    div_zero  = (rs2_data_i == '0);
    overflow  = signed_op && (rs1_data_i == MIN_INT) && (rs2_data_i == '1);
    if (div_zero) special_res = rem_op ? rs1_data_i : '1;
    else          special_res = rem_op ? '0 : MIN_INT;

    // Partial remainder stays below the divisor, so the low XLEN bits of the
    // difference are exact whenever no borrow occurs.
    rem_shift = {rem_q, quo_q[XLEN-1]};
    step_ge   = (rem_shift >= {1'b0, dvs_q});
    rem_step  = step_ge ? (rem_shift[XLEN-1:0] - dvs_q) : rem_shift[XLEN-1:0];

    if (is_rem_q) fix_res = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    else          fix_res = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    rd_d      = rd_q;
    wr_en_d   = 1'b0;
    dr_d      = dr_q;
    data_d    = data_q;

    if (kill_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (start_i) begin
            if (div_zero || overflow) begin
              state_d = ST_DONE;
              data_d  = special_res;
              dr_d    = rd_i;
              wr_en_d = (rd_i != 5'd0);
            end else begin
              state_d   = ST_CALC;
              cnt_d     = '0;
              quo_d     = a_mag;
              rem_d     = '0;
              dvs_d     = b_mag;
              neg_quo_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              is_rem_d  = rem_op;
              rd_d      = rd_i;
            end
          end
        end
        ST_CALC: begin
          quo_d = {quo_q[XLEN-2:0], step_ge};
          rem_d = rem_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_STEP) state_d = ST_FIX;
        end
        ST_FIX: begin
          state_d = ST_DONE;
          data_d  = fix_res;
          dr_d    = rd_q;
          wr_en_d = (rd_q != 5'd0);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      rd_q      <= '0;
      wr_en_q   <= 1'b0;
      dr_q      <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      rd_q      <= rd_d;
      wr_en_q   <= wr_en_d;
      dr_q      <= dr_d;
      data_q    <= data_d;
    end
  end

  // A flush arriving in the DONE cycle must still cancel the registered strobe.
  assign busy_o      = busy;
  assign reg_wr_en_o = wr_en_q & ~kill_i;
  assign reg_dr_o    = dr_q;
  assign reg_data_o  = data_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver queues expected writebacks with
// their due cycle, a negedge monitor pops and checks every write strobe.
module tb_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic [4:0]  rd_i = '0;
  logic        kill_i = 1'b0;
  logic        busy_o;
  logic        reg_wr_en_o;
  logic [4:0]  reg_dr_o;
  logic [31:0] reg_data_o;

  div_unit #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .op_i(op_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_i(rd_i),
    .kill_i(kill_i), .busy_o(busy_o), .reg_wr_en_o(reg_wr_en_o),
    .reg_dr_o(reg_dr_o), .reg_data_o(reg_data_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_fail = 0;

  // Reference: RISC-V M-extension division semantics in plain arithmetic.
  function automatic bit is_special(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  task automatic go(input int k);
    repeat (k) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Called at posedge+1 of cycle N; returns in cycle N+1 with start low.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_data,
                       input bit expect_wr, output int lat);
    exp_t e;
    lat = is_special(op, a, b) ? 1 : 34;
    start_i = 1'b1;
    op_i = op;
    rs1_data_i = a;
    rs2_data_i = b;
    rd_i = rd;
    if (expect_wr && rd != 5'd0) begin
      e.rd = rd;
      e.data = exp_data;
      e.due = cyc + lat;
      sbq.push_back(e);
    end
    go(1);
    start_i = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(negedge clk_i) begin
    if (reg_wr_en_o === 1'b1) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h at cycle %0d, want no strobe",
                 reg_dr_o, reg_data_o, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (reg_dr_o !== e.rd || reg_data_o !== e.data || cyc != e.due) begin
          n_fail++;
          $display("FAIL wb: got rd=%0d data=%h cycle=%0d, want rd=%0d data=%h cycle=%0d",
                   reg_dr_o, reg_data_o, cyc, e.rd, e.data, e.due);
        end
      end
    end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
      exp_t e;
      e = sbq.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL wb_missing: got no strobe by cycle %0d, want rd=%0d data=%h",
               e.due, e.rd, e.data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, want $finish before time limit");
    $fatal(1, "bench timeout");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_v;
  } dir_t;

  dir_t dir_tab[$] = '{
    '{2'b01, 32'd100, 32'd7, 5'd5, 32'd14},
    '{2'b11, 32'd100, 32'd7, 5'd5, 32'd2},
    '{2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD},
    '{2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF},
    '{2'b00, 32'd7, 32'hFFFF_FFFE, 5'd3, 32'hFFFF_FFFD},
    '{2'b10, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'd1},
    '{2'b01, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF},
    '{2'b10, 32'h1234_5678, 32'd0, 5'd7, 32'h1234_5678},
    '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000},
    '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0},
    '{2'b01, 32'd9, 32'd3, 5'd0, 32'd3},
    '{2'b11, 32'hFFFF_FFFF, 32'd16, 5'd31, 32'd15}
  };

  initial begin
    int lat;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;

    #1;
    check("reset_outputs", {27'd0, busy_o, reg_wr_en_o, reg_dr_o[0], 2'b00} |
          {reg_dr_o, reg_data_o[26:0]}, 32'd0);
    check("reset_data", reg_data_o, 32'd0);

    // Release reset and start in the same (first) cycle; directed results
    // run back-to-back, each new start in the previous DONE cycle.
    go(1);
    rst_n_i = 1'b1;
    foreach (dir_tab[i]) begin
      issue(dir_tab[i].op, dir_tab[i].a, dir_tab[i].b, dir_tab[i].rd,
            dir_tab[i].exp_v, 1'b1, lat);
      go(lat - 1);
    end
    go(3);

    // Start while busy is ignored.
    issue(2'b01, 32'd1000, 32'd10, 5'd9, 32'd100, 1'b1, lat);
    go(4);
    check("busy_in_calc", {31'd0, busy_o}, 32'd1);
    start_i = 1'b1; op_i = 2'b01; rs1_data_i = 32'd7; rs2_data_i = 32'd7; rd_i = 5'd10;
    go(1);
    start_i = 1'b0;
    go(40);

    // Kill in N+10: idle in N+11, no strobe ever.
    issue(2'b00, 32'd12345, 32'hFFFF_FFFB, 5'd11, 32'd0, 1'b0, lat);
    go(9);
    kill_i = 1'b1;
    go(1);
    kill_i = 1'b0;
    check("busy_after_kill", {31'd0, busy_o}, 32'd0);
    go(40);

    // Kill wins over a simultaneous start.
    start_i = 1'b1; kill_i = 1'b1; op_i = 2'b01; rs1_data_i = 32'd8; rs2_data_i = 32'd2; rd_i = 5'd12;
    go(1);
    start_i = 1'b0; kill_i = 1'b0;
    check("kill_beats_start", {31'd0, busy_o}, 32'd0);
    go(40);

    // Kill in the DONE cycle suppresses the strobe.
    issue(2'b01, 32'd50, 32'd5, 5'd12, 32'd10, 1'b0, lat);
    go(33);
    kill_i = 1'b1;
    go(1);
    kill_i = 1'b0;
    go(3);

    // Reset mid-operation, then start in the first cycle after release.
    issue(2'b11, 32'd99, 32'd4, 5'd13, 32'd3, 1'b0, lat);
    go(19);
    rst_n_i = 1'b0;
    #1;
    check("midrst_ctrl", {27'd0, busy_o, reg_wr_en_o, 3'd0} | {27'd0, reg_dr_o}, 32'd0);
    check("midrst_data", reg_data_o, 32'd0);
    go(2);
    rst_n_i = 1'b1;
    issue(2'b01, 32'd77, 32'd7, 5'd14, 32'd11, 1'b1, lat);
    go(lat - 1);

    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 9))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
        3: begin a = $urandom; b = 32'hFFFF_FFFF - $urandom_range(0, 9); end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      issue(op, a, b, rd, ref_div(op, a, b), 1'b1, lat);
      go(lat - 1);
      if ($urandom_range(0, 1) == 0) go($urandom_range(1, 3));
    end

    go(40);
    check("scoreboard_drained", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
